// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, sync polarity levels and a ceil-log2 helper
// for the VGA/LCD timing generator.
package vga_timing_pkg;

  localparam logic ACTIVE_LOW  = 1'b0;
  localparam logic ACTIVE_HIGH = 1'b1;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 29;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;

  // 800x600@60 (40 MHz pixel clock), positive syncs
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam logic SVGA800_POL    = ACTIVE_HIGH;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/vga_ce_delay.sv
// Pixel-enable gated shift register; DLY=0 is a plain wire-through.
module vga_ce_delay #(
  parameter int             W       = 1,
  parameter int             DLY     = 0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         dclk,
  input  logic         clr,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DLY == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{dclk, clr, ce};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] stage [DLY];

    always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
        for (int i = 0; i < DLY; i++) stage[i] <= RST_VAL;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DLY-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: sync/DE/coordinates one ce-step behind
// the internal counters, plus line/frame strobes, frame count and a delayed sync group.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter logic H_POL    = ACTIVE_LOW,
  parameter logic V_POL    = ACTIVE_LOW,
  parameter int   CW       = 10,
  parameter int   FCW      = 8,
  parameter int   PIPE_DLY = 0
) (
  input  logic           dclk,
  input  logic           clr,
  input  logic           ce,
  output logic [CW-1:0]  hcount,
  output logic [CW-1:0]  vcount,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt,
  output logic           hsync_d,
  output logic           vsync_d,
  output logic           de_d
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  if (clog2_f(H_TOTAL) > CW) begin : g_err_htotal
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (clog2_f(V_TOTAL) > CW) begin : g_err_vtotal
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (H_SYNC == 0 || H_ACTIVE == 0 || V_SYNC == 0 || V_ACTIVE == 0) begin : g_err_zero
    $error("vga_timing_gen: sync and active widths must be non-zero");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_err_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..15");
  end

  // Region bounds are CW+1 bits wide since an end bound may equal 2^CW.
  localparam logic [CW:0]   H_SYNC_END = (CW+1)'(H_SYNC);
  localparam logic [CW:0]   H_ACT_BEG  = (CW+1)'(H_SYNC + H_BP);
  localparam logic [CW:0]   H_ACT_END  = (CW+1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW:0]   V_SYNC_END = (CW+1)'(V_SYNC);
  localparam logic [CW:0]   V_ACT_BEG  = (CW+1)'(V_SYNC + V_BP);
  localparam logic [CW:0]   V_ACT_END  = (CW+1)'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CW-1:0] H_OFS      = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_OFS      = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  logic [CW-1:0]  hc;
  logic [CW-1:0]  vc;
  logic [FCW-1:0] fc;
  logic [CW:0]    hx;
  logic [CW:0]    vx;
  logic           hs_on;
  logic           vs_on;
  logic           hact;
  logic           vact;
  logic [CW-1:0]  x_next;
  logic [CW-1:0]  y_next;
  logic [2:0]     dly_q;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc <= '0;
      vc <= '0;
      fc <= '0;
    end else if (ce) begin
      if (hc != H_LAST) begin
        hc <= hc + 1'b1;
      end else begin
        hc <= '0;
        if (vc != V_LAST) begin
          vc <= vc + 1'b1;
        end else begin
          vc <= '0;
          fc <= fc + 1'b1;
        end
      end
    end
  end

  assign hx     = {1'b0, hc};
  assign vx     = {1'b0, vc};
  assign hs_on  = hx < H_SYNC_END;
  assign vs_on  = vx < V_SYNC_END;
  assign hact   = (hx >= H_ACT_BEG) && (hx < H_ACT_END);
  assign vact   = (vx >= V_ACT_BEG) && (vx < V_ACT_END);
  assign x_next = hact ? hc - H_OFS : '0;
  assign y_next = vact ? vc - V_OFS : '0;

  // Strobes are re-evaluated every dclk so they never stretch while ce stays high.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= ce && (hc == '0);
      frame_start <= ce && (hc == '0) && (vc == '0);
      if (ce) begin
        hcount    <= hc;
        vcount    <= vc;
        hsync     <= hs_on ? H_POL : ~H_POL;
        vsync     <= vs_on ? V_POL : ~V_POL;
        de        <= hact && vact;
        x         <= x_next;
        y         <= y_next;
        frame_cnt <= fc;
      end
    end
  end

  vga_ce_delay #(
    .W       (3),
    .DLY     (PIPE_DLY),
    .RST_VAL ({~H_POL, ~V_POL, 1'b0})
  ) u_sync_dly (
    .dclk (dclk),
    .clr  (clr),
    .ce   (ce),
    .d    ({hsync, vsync, de}),
    .q    (dly_q)
  );

  assign hsync_d = dly_q[2];
  assign vsync_d = dly_q[1];
  assign de_d    = dly_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny positive-sync
// instance with PIPE_DLY=3, both checked every half-cycle against a position model.
module tb_vga_timing_gen;

  logic dclk = 1'b0;
  always #5 dclk = ~dclk;

  logic clr  = 1'b1;
  logic ce_d = 1'b0;
  logic ce_s = 1'b0;

  logic [9:0] d_hcount, d_vcount, d_x, d_y;
  logic       d_hsync, d_vsync, d_de, d_ls, d_fs, d_hsd, d_vsd, d_ded;
  logic [7:0] d_fcnt;

  logic [3:0] s_hcount, s_vcount, s_x, s_y;
  logic       s_hsync, s_vsync, s_de, s_ls, s_fs, s_hsd, s_vsd, s_ded;
  logic [7:0] s_fcnt;

  vga_timing_gen u_def (
    .dclk(dclk), .clr(clr), .ce(ce_d),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .de(d_de), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs),
    .frame_cnt(d_fcnt), .hsync_d(d_hsd), .vsync_d(d_vsd), .de_d(d_ded)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FCW(8), .PIPE_DLY(3)
  ) u_sml (
    .dclk(dclk), .clr(clr), .ce(ce_s),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .de(s_de), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs),
    .frame_cnt(s_fcnt), .hsync_d(s_hsd), .vsync_d(s_vsd), .de_d(s_ded)
  );

  typedef struct {
    logic [63:0] hcount, vcount, hsync, vsync, de, x, y, ls, fs, fcnt, hsd, vsd, ded;
  } rec_t;

  rec_t   sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint n_d = 0, n_s = 0;
  bit     lce_d = 1'b0, lce_s = 1'b0;
  longint cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Undelayed outputs after n ce-steps since reset (n<=0 means reset state).
  function automatic rec_t model_base(input int inst, input longint n);
    int hs, hb, ha, ht, vs, vb, va, vt;
    bit hp, vp, hact, vact;
    longint p, h, v;
    rec_t e;
    if (inst == 0) begin
      hs = 96; hb = 48; ha = 640; ht = 800; vs = 2; vb = 29; va = 480; vt = 521; hp = 0; vp = 0;
    end else begin
      hs = 2; hb = 1; ha = 4; ht = 8; vs = 1; vb = 1; va = 3; vt = 6; hp = 1; vp = 1;
    end
    e = '{default: '0};
    if (n <= 0) begin
      e.hsync = 64'(!hp);
      e.vsync = 64'(!vp);
      return e;
    end
    p    = (n - 1) % (ht * vt);
    h    = p % ht;
    v    = p / ht;
    hact = (h >= hs + hb) && (h < hs + hb + ha);
    vact = (v >= vs + vb) && (v < vs + vb + va);
    e.hcount = 64'(h);
    e.vcount = 64'(v);
    e.hsync  = 64'((h < hs) ? hp : !hp);
    e.vsync  = 64'((v < vs) ? vp : !vp);
    e.de     = 64'(hact && vact);
    e.x      = hact ? 64'(h - (hs + hb)) : 64'd0;
    e.y      = vact ? 64'(v - (vs + vb)) : 64'd0;
    e.fcnt   = 64'(((n - 1) / (ht * vt)) % 256);
    return e;
  endfunction

  function automatic rec_t model(input int inst, input longint n, input bit lce);
    rec_t e, d;
    e = model_base(inst, n);
    d = model_base(inst, n - ((inst == 0) ? 0 : 3));
    e.hsd = d.hsync;
    e.vsd = d.vsync;
    e.ded = d.de;
    e.ls  = 64'(lce && (e.hcount == 0));
    e.fs  = 64'(lce && (e.hcount == 0) && (e.vcount == 0));
    return e;
  endfunction

  function automatic rec_t obs_def();
    rec_t o;
    o.hcount = 64'(d_hcount); o.vcount = 64'(d_vcount); o.hsync = 64'(d_hsync);
    o.vsync = 64'(d_vsync); o.de = 64'(d_de); o.x = 64'(d_x); o.y = 64'(d_y);
    o.ls = 64'(d_ls); o.fs = 64'(d_fs); o.fcnt = 64'(d_fcnt);
    o.hsd = 64'(d_hsd); o.vsd = 64'(d_vsd); o.ded = 64'(d_ded);
    return o;
  endfunction

  function automatic rec_t obs_sml();
    rec_t o;
    o.hcount = 64'(s_hcount); o.vcount = 64'(s_vcount); o.hsync = 64'(s_hsync);
    o.vsync = 64'(s_vsync); o.de = 64'(s_de); o.x = 64'(s_x); o.y = 64'(s_y);
    o.ls = 64'(s_ls); o.fs = 64'(s_fs); o.fcnt = 64'(s_fcnt);
    o.hsd = 64'(s_hsd); o.vsd = 64'(s_vsd); o.ded = 64'(s_ded);
    return o;
  endfunction

  task automatic compare_all(input string pfx, input rec_t o, input rec_t e);
    check_eq({pfx, ".hcount"},      o.hcount, e.hcount);
    check_eq({pfx, ".vcount"},      o.vcount, e.vcount);
    check_eq({pfx, ".hsync"},       o.hsync,  e.hsync);
    check_eq({pfx, ".vsync"},       o.vsync,  e.vsync);
    check_eq({pfx, ".de"},          o.de,     e.de);
    check_eq({pfx, ".x"},           o.x,      e.x);
    check_eq({pfx, ".y"},           o.y,      e.y);
    check_eq({pfx, ".line_start"},  o.ls,     e.ls);
    check_eq({pfx, ".frame_start"}, o.fs,     e.fs);
    check_eq({pfx, ".frame_cnt"},   o.fcnt,   e.fcnt);
    check_eq({pfx, ".hsync_d"},     o.hsd,    e.hsd);
    check_eq({pfx, ".vsync_d"},     o.vsd,    e.vsd);
    check_eq({pfx, ".de_d"},        o.ded,    e.ded);
  endtask

  task automatic compare_pair(input string ph);
    rec_t e;
    e = sb_q.pop_front();
    compare_all({"def.", ph}, obs_def(), e);
    e = sb_q.pop_front();
    compare_all({"sml.", ph}, obs_sml(), e);
  endtask

  // One dclk: drive at negedge, check held state, then check after the posedge.
  task automatic tick(input bit ced, input bit ces, input bit clr_v);
    @(negedge dclk);
    ce_d = ced;
    ce_s = ces;
    clr  = clr_v;
    if (clr_v) begin
      n_d = 0; n_s = 0; lce_d = 1'b0; lce_s = 1'b0;
    end
    sb_q.push_back(model(0, n_d, lce_d));
    sb_q.push_back(model(1, n_s, lce_s));
    #1;
    compare_pair("pre");
    @(posedge dclk);
    lce_d = !clr_v && ced;
    lce_s = !clr_v && ces;
    if (lce_d) n_d++;
    if (lce_s) n_s++;
    sb_q.push_back(model(0, n_d, lce_d));
    sb_q.push_back(model(1, n_s, lce_s));
    #1;
    compare_pair("post");
    cyc++;
  endtask

  initial begin
    int     hs_low, vs_low, de_cnt, de_first_h, de_first_v, fc_zero, fc_ff, k;
    longint last_fs;
    bit     seen_de;

    hs_low = 0; vs_low = 0; de_cnt = 0; de_first_h = -1; de_first_v = -1;
    fc_zero = 0; fc_ff = 0; seen_de = 1'b0; last_fs = -1;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);

    // Continuous ce: 33 default lines, ~550 small frames (two frame_cnt wraps).
    for (int i = 1; i <= 26400; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (i <= 800 && d_hsync == 1'b0) hs_low++;
      if (d_vsync == 1'b0) vs_low++;
      if (d_de == 1'b1) begin
        de_cnt++;
        if (!seen_de) begin
          seen_de = 1'b1; de_first_h = int'(d_hcount); de_first_v = int'(d_vcount);
        end
      end
      if (s_fs) begin
        if (last_fs >= 0) check_eq("sml.fs_period_ce1", 64'(cyc - last_fs), 64'd48);
        last_fs = cyc;
        if (s_fcnt == 8'd0)   fc_zero++;
        if (s_fcnt == 8'd255) fc_ff++;
      end
    end
    check_eq("def.hsync_low_per_line", 64'(hs_low), 64'd96);
    check_eq("def.vsync_low_cycles",   64'(vs_low), 64'd1600);
    check_eq("def.de_cycles_33_lines", 64'(de_cnt), 64'd1280);
    check_eq("def.de_first_hcount",    64'(de_first_h), 64'd144);
    check_eq("def.de_first_vcount",    64'(de_first_v), 64'd31);
    check_eq("sml.fcnt_zero_starts",   64'(fc_zero), 64'd3);
    check_eq("sml.fcnt_255_starts",    64'(fc_ff), 64'd2);

    // ce every second dclk: periods double, strobes stay one dclk wide.
    last_fs = -1;
    for (int i = 0; i < 3200; i++) begin
      tick(i[0], i[0], 1'b0);
      if (s_fs) begin
        if (last_fs >= 0) check_eq("sml.fs_period_ce2", 64'(cyc - last_fs), 64'd96);
        last_fs = cyc;
      end
    end

    // Mid-line asynchronous reset, then restart from (0,0).
    k = 0;
    while (d_hcount != 10'd400 && k < 1000) begin
      tick(1'b1, 1'b1, 1'b0);
      k++;
    end
    check_eq("def.reach_hcount_400", 64'(d_hcount), 64'd400);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
